// File: rtl/uart_pkg.sv
// Shared UART types and width constants for the receive path.
// The rx state encoding is the same whether or not UART_RX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int OVS_DEFAULT = 16;

    // Tick counter covers the longest stop period (32 ticks); bit counter covers 9 data bits.
    localparam int S_CNT_W = 5;
    localparam int N_CNT_W = 4;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous inputs (rx, CTS, ...).
// RESET_VAL selects the level the chain holds while in reset.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 16x (OVS) oversampled deserialiser with a one-cycle completion strobe.
// Optional even-parity bit and par_err flag are enabled by defining UART_RX_PARITY_EN.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int OVS     = OVS_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            rx,
    output logic            rx_done_tick,
    output logic [DBIT-1:0] dout,
    output logic            frame_err,
    output logic            par_err
);

    localparam logic [S_CNT_W-1:0] S_MID  = S_CNT_W'(OVS/2 - 1);
    localparam logic [S_CNT_W-1:0] S_BIT  = S_CNT_W'(OVS - 1);
    localparam logic [S_CNT_W-1:0] S_STOP = S_CNT_W'(SB_TICK - 1);
    localparam logic [N_CNT_W-1:0] N_LAST = N_CNT_W'(DBIT - 1);

    logic w_rxS;

    rx_state_t          r_state,    w_stateNext;
    logic [S_CNT_W-1:0] r_s,        w_sNext;
    logic [N_CNT_W-1:0] r_n,        w_nNext;
    logic [DBIT-1:0]    r_shift,    w_shiftNext;
    logic [DBIT-1:0]    r_dout,     w_doutNext;
    logic               r_frameErr, w_frameErrNext;
    logic               r_done,     w_doneNext;
`ifdef UART_RX_PARITY_EN
    logic               r_parBit,   w_parBitNext;
    logic               r_parErr,   w_parErrNext;
`endif

    uart_sync2 #(.RESET_VAL(1'b1)) u_rxSync (
        .clk   (clk),
        .reset (reset),
        .i_d   (rx),
        .o_q   (w_rxS)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_s        <= '0;
            r_n        <= '0;
            r_shift    <= '0;
            r_dout     <= '0;
            r_frameErr <= 1'b0;
            r_done     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parBit   <= 1'b0;
            r_parErr   <= 1'b0;
`endif
        end else begin
            r_state    <= w_stateNext;
            r_s        <= w_sNext;
            r_n        <= w_nNext;
            r_shift    <= w_shiftNext;
            r_dout     <= w_doutNext;
            r_frameErr <= w_frameErrNext;
            r_done     <= w_doneNext;
`ifdef UART_RX_PARITY_EN
            r_parBit   <= w_parBitNext;
            r_parErr   <= w_parErrNext;
`endif
        end
    end

    // The start edge is looked for every clk; all later sampling is paced by s_tick.
    always_comb begin
        w_stateNext    = r_state;
        w_sNext        = r_s;
        w_nNext        = r_n;
        w_shiftNext    = r_shift;
        w_doutNext     = r_dout;
        w_frameErrNext = r_frameErr;
        w_doneNext     = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_parBitNext   = r_parBit;
        w_parErrNext   = r_parErr;
`endif
        case (r_state)
            IDLE: begin
                if (!w_rxS) begin
                    w_stateNext = START;
                    w_sNext     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (r_s == S_MID) begin
                        if (!w_rxS) begin
                            w_stateNext = DATA;
                            w_sNext     = '0;
                            w_nNext     = '0;
                        end else begin
                            w_stateNext = IDLE;
                        end
                    end else begin
                        w_sNext = r_s + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (r_s == S_BIT) begin
                        w_sNext     = '0;
                        w_shiftNext = {w_rxS, r_shift[DBIT-1:1]};
                        if (r_n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            w_stateNext = PARITY;
`else
                            w_stateNext = STOP;
`endif
                        end else begin
                            w_nNext = r_n + 1'b1;
                        end
                    end else begin
                        w_sNext = r_s + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (r_s == S_BIT) begin
                        w_sNext      = '0;
                        w_parBitNext = w_rxS;
                        w_stateNext  = STOP;
                    end else begin
                        w_sNext = r_s + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (r_s == S_STOP) begin
                        w_doutNext     = r_shift;
                        w_frameErrNext = ~w_rxS;
                        w_doneNext     = 1'b1;
`ifdef UART_RX_PARITY_EN
                        w_parErrNext   = ^{r_shift, r_parBit};
`endif
                        w_stateNext    = IDLE;
                    end else begin
                        w_sNext = r_s + 1'b1;
                    end
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    assign rx_done_tick = r_done;
    assign dout         = r_dout;
    assign frame_err    = r_frameErr;
`ifdef UART_RX_PARITY_EN
    assign par_err      = r_parErr;
`else
    assign par_err      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed self-checking bench for uart_rx_core (8N1 default, 8E1 with UART_RX_PARITY_EN).
// s_tick fires once every 10 clk, so one bit period is 16 ticks = 160 clk.
module tb_uart_rx_core;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_tick = 1'b0;
    logic       rx;
    logic       rx_done_tick;
    logic [7:0] dout;
    logic       frame_err;
    logic       par_err;

    int nVectors     = 0;
    int nMiscompares = 0;

    int tickDiv       = 0;
    int cycleCnt      = 0;
    int doneCount     = 0;
    int lastDoneCycle = 0;
    int prevDoneCycle = 0;
    int doneBase;

`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    uart_rx_core dut (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .rx           (rx),
        .rx_done_tick (rx_done_tick),
        .dout         (dout),
        .frame_err    (frame_err),
        .par_err      (par_err)
    );

    always #5 clk = ~clk;

    // Free-running baud tick, independent of the DUT reset like the shared generator.
    always @(posedge clk) begin
        tickDiv  <= (tickDiv == 9) ? 0 : tickDiv + 1;
        s_tick   <= (tickDiv == 9);
        cycleCnt <= cycleCnt + 1;
    end

    // Count completion strobes and remember when the last two occurred.
    always @(posedge clk) begin
        if (rx_done_tick === 1'b1) begin
            doneCount     <= doneCount + 1;
            prevDoneCycle <= lastDoneCycle;
            lastDoneCycle <= cycleCnt;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nVectors++;
        assert (observed === expected)
        else begin
            nMiscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Returns 1 ns after the clk edge on which the DUT consumed the n-th s_tick.
    task automatic waitTicks(input int n);
        repeat (n) begin
            @(negedge clk);
            while (s_tick !== 1'b1) @(negedge clk);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sendBit(input logic b);
        rx = b;
        waitTicks(16);
    endtask

    // A bad stop bit is held low past its mid-bit sample, then released so the
    // receiver's retry of START sees an idle line rather than a new start bit.
    task automatic applyStimulus(input logic [7:0] data, input logic stopOk,
                                 input logic parBit);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(data[i]);
`ifdef UART_RX_PARITY_EN
        sendBit(parBit);
`else
        if (parBit) rx = 1'b1;
`endif
        if (stopOk) begin
            sendBit(1'b1);
        end else begin
            rx = 1'b0;
            waitTicks(12);
            rx = 1'b1;
            waitTicks(4);
        end
        rx = 1'b1;
    endtask

    initial begin
        rx    = 1'b1;
        reset = 1'b1;
        #23;
        checkOutput("reset_dout", {24'd0, dout}, 32'h00);
        checkOutput("reset_frame_err", {31'd0, frame_err}, 32'd0);
        checkOutput("reset_par_err", {31'd0, par_err}, 32'd0);
        checkOutput("reset_done", {31'd0, rx_done_tick}, 32'd0);
        reset = 1'b0;
        waitTicks(4);

        doneBase = doneCount;
        applyStimulus(8'hA5, 1'b1, 1'b0);
        checkOutput("a5_strobes", doneCount - doneBase, 32'd1);
        checkOutput("a5_dout", {24'd0, dout}, 32'hA5);
        checkOutput("a5_frame_err", {31'd0, frame_err}, 32'd0);
        checkOutput("a5_par_err", {31'd0, par_err}, 32'd0);
        checkOutput("a5_done_low", {31'd0, rx_done_tick}, 32'd0);

        doneBase = doneCount;
        rx = 1'b0;
        waitTicks(4);
        rx = 1'b1;
        waitTicks(16);
        checkOutput("glitch_strobes", doneCount - doneBase, 32'd0);
        checkOutput("glitch_dout", {24'd0, dout}, 32'hA5);

        doneBase = doneCount;
        applyStimulus(8'h3C, 1'b0, 1'b0);
        checkOutput("badstop_strobes", doneCount - doneBase, 32'd1);
        checkOutput("badstop_dout", {24'd0, dout}, 32'h3C);
        checkOutput("badstop_frame_err", {31'd0, frame_err}, 32'd1);
        waitTicks(16);
        applyStimulus(8'h11, 1'b1, 1'b0);
        checkOutput("clean11_strobes", doneCount - doneBase, 32'd2);
        checkOutput("clean11_dout", {24'd0, dout}, 32'h11);
        checkOutput("clean11_frame_err", {31'd0, frame_err}, 32'd0);

        // Break: the line stays low across two frame times, released just
        // before the third START mid-bit sample.
        doneBase = doneCount;
        rx = 1'b0;
        waitTicks(16 * FRAME_BITS + 16 * FRAME_BITS - 12);
        rx = 1'b1;
        waitTicks(12 + 16);
        checkOutput("break_strobes", doneCount - doneBase, 32'd2);
        checkOutput("break_dout", {24'd0, dout}, 32'h00);
        checkOutput("break_frame_err", {31'd0, frame_err}, 32'd1);
        applyStimulus(8'h11, 1'b1, 1'b0);
        checkOutput("postbreak_frame_err", {31'd0, frame_err}, 32'd0);

        doneBase = doneCount;
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkOutput("b2b_dout00", {24'd0, dout}, 32'h00);
        applyStimulus(8'hFF, 1'b1, 1'b0);
        checkOutput("b2b_doutff", {24'd0, dout}, 32'hFF);
        checkOutput("b2b_strobes", doneCount - doneBase, 32'd2);
        checkOutput("b2b_interval", lastDoneCycle - prevDoneCycle, 32'(FRAME_BITS * 160));

        // 0x5A: start, bits 0..3, then reset halfway through bit 4.
        doneBase = doneCount;
        sendBit(1'b0);
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b1);
        rx = 1'b1;
        waitTicks(8);
        reset = 1'b1;
        #20;
        reset = 1'b0;
        #1;
        checkOutput("rst_dout", {24'd0, dout}, 32'h00);
        checkOutput("rst_frame_err", {31'd0, frame_err}, 32'd0);
        checkOutput("rst_par_err", {31'd0, par_err}, 32'd0);
        waitTicks(32);
        checkOutput("rst_strobes", doneCount - doneBase, 32'd0);
        applyStimulus(8'h81, 1'b1, 1'b0);
        checkOutput("post_rst_strobes", doneCount - doneBase, 32'd1);
        checkOutput("post_rst_dout", {24'd0, dout}, 32'h81);

`ifdef UART_RX_PARITY_EN
        applyStimulus(8'h03, 1'b1, 1'b0);
        checkOutput("par_ok_dout", {24'd0, dout}, 32'h03);
        checkOutput("par_ok_par_err", {31'd0, par_err}, 32'd0);
        applyStimulus(8'h03, 1'b1, 1'b1);
        checkOutput("par_bad_par_err", {31'd0, par_err}, 32'd1);
        checkOutput("par_bad_frame_err", {31'd0, frame_err}, 32'd0);
`else
        checkOutput("par_err_const", {31'd0, par_err}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
UART receive stage that deserialises the asynchronous serial line into parallel words. Uses a 16x oversampling tick from the shared baud generator. On each completed frame it presents one word plus a single-cycle completion strobe. That strobe directly drives the set_flag/din inputs of the downstream receive flag buffer.

Parameters:
DBIT, 8, data bits per frame (5..9)
SB_TICK, 16, oversampling ticks in the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2)
OVS, 16, oversampling ratio (ticks per bit; must be a power of 2, >= 8)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
s_tick  in  1  oversampling enable, one clk wide, OVS per bit period
rx  in  1  raw serial input, idle high, asynchronous to clk
rx_done_tick  out  1  one-cycle strobe: frame complete, dout/frame_err valid
dout  out  DBIT  received word, LSB first on the line
frame_err  out  1  stop bit sampled low on the last completed frame
par_err  out  1  parity mismatch on the last completed frame (0 without macro)

Behaviour:
- Reset is asynchronous, active-high, clock is clk. Reset values:
  - state = IDLE
  - rx_done_tick = 0
  - dout = 0
  - frame_err = 0
  - par_err = 0
  - tick counter s = 0
  - bit counter n = 0
  - sync flops = 1 (line idle)
- rx passes a 2-FF synchronizer, so rx_s lags rx by 2 clk. All sampling uses rx_s.
- State machine:
  - IDLE, START, DATA, [PARITY], STOP.
  - The s counter advances only on s_tick. The n counter and shift register are internal.
  - IDLE: rx_s == 0 -> START, s = 0. This check is made every clk, not only on s_tick.
  - START: on s_tick with s == OVS/2-1 (mid-bit):
    - rx_s == 0 -> DATA, s = 0, n = 0.
    - rx_s == 1 -> IDLE (glitch rejected; no strobe, outputs unchanged).
  - DATA: on s_tick with s == OVS-1:
    - shift rx_s into the shift register MSB (right shift), s = 0.
    - n == DBIT-1 -> STOP (or PARITY when the macro is set); otherwise n++.
  - STOP: on s_tick with s == SB_TICK-1:
    - dout <= shift register.
    - frame_err <= ~rx_s.
    - rx_done_tick <= 1 for exactly one clk.
    - -> IDLE.
- Latency: rx_done_tick is registered, high in the clk after the final stop-sample s_tick.
  - dout, frame_err and par_err update in that same cycle.
  - They hold their values until the next completion; they never change mid-frame.
- Break condition (rx held low):
  - The frame completes with frame_err = 1.
  - The block returns to IDLE and immediately re-enters START. Every following frame then also ends with frame_err = 1.
- Back-to-back frames: a start edge in the first clk after STOP -> IDLE is accepted. No dead time is required.
- s_tick asserted in the same clk as the IDLE falling-edge detect: the tick is not counted. Counting begins on the next s_tick.
- Reset mid-frame: immediate return to IDLE, the partial word is discarded, no strobe.
- When DBIT < 8, dout holds the received bits right-justified.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, one bit period long, sampled at s == OVS-1.
  - Even parity over the data bits plus the parity bit must equal 0.
  - par_err <= mismatch, updated with rx_done_tick.
- Not defined:
  - No PARITY state; DATA goes straight to STOP.
  - par_err is a constant 0.
  - Frame length = 1 + DBIT + stop.

Decomposition:
- Package uart_pkg holds:
  - the rx state enum (IDLE, START, DATA, PARITY, STOP), one shared encoding for all builds
  - OVS_DEFAULT = 16
  - the tick-counter width constant clog2(32) = 5, sized to cover SB_TICK max
  - the bit-counter width constant clog2(9) = 4
- One sub-module: uart_sync2, a 2-flop synchronizer with parameterised reset value (1 here). It is reused by other async inputs such as CTS.

Test Plan:
- Frame 0xA5, 1 stop bit, s_tick every 10 clk -> exactly one rx_done_tick, dout = 0xA5, frame_err = 0, par_err = 0.
- rx low for 4 ticks then high (glitch) -> no rx_done_tick; state returns to IDLE; dout keeps its previous value.
- Frame 0x3C with stop bit driven 0 -> rx_done_tick, dout = 0x3C, frame_err = 1. The next clean frame 0x11 -> frame_err = 0.
- Back-to-back 0x00 then 0xFF with zero idle -> two strobes exactly 10 bit-periods (160 ticks) apart, dout = 0x00 then 0xFF.
- reset pulsed during DATA bit 4 of 0x5A -> no strobe, all outputs 0. A following frame 0x81 -> dout = 0x81.
- With UART_RX_PARITY_EN: 0x03 with parity bit 0 -> par_err = 0; 0x03 with parity bit 1 -> par_err = 1.
